// File: rtl/dds_wavegen.sv
// Purpose: DDS waveform generator (phase accumulator, quarter-wave sine ROM, sine/triangle/saw/square, gain, offset-binary out).
// Latency: 4 cycles from an enabled edge to wave_valid; one sample per clock when en is held.
// Backpressure: none; en is a per-cycle strobe and samples are never stalled or dropped except by rst.
module dds_wavegen #(
  parameter int PHASE_W  = 32,
  parameter int TABLE_AW = 6,
  parameter int AMP_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_load,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic [1:0]         mode,
  input  logic [8:0]         amp_scale,
  output logic [AMP_W-1:0]   wave_out,
  output logic               wave_valid
);

  localparam int N      = TABLE_AW + 2;
  localparam int DEPTH  = 1 << TABLE_AW;
  localparam int RW     = AMP_W - 1;
  localparam int M      = (1 << (AMP_W - 1)) - 1;
  localparam int TRI_SH = AMP_W - 1 - TABLE_AW;
  localparam int SW     = (N > AMP_W) ? N : AMP_W;
  localparam int SHL    = (AMP_W >= N) ? AMP_W - N : 0;
  localparam int SHR    = (N > AMP_W) ? N - AMP_W : 0;
  localparam int PW     = AMP_W + 10;

  localparam logic signed [AMP_W-1:0] POS_M  = AMP_W'(M);
  localparam logic signed [AMP_W-1:0] NEG_M  = AMP_W'(-M);
  localparam logic signed [SW-1:0]    NEG_MW = SW'(-M);
  localparam logic [AMP_W-1:0]        MID    = AMP_W'(1 << (AMP_W - 1));

  typedef enum logic [1:0] {MODE_SINE, MODE_TRI, MODE_SAW, MODE_SQR} mode_e;
  typedef logic [RW-1:0] rom_word_t;

  // Quarter-wave table rom[k] = round(M*sin(pi/2*(k+0.5)/DEPTH)), built at elaboration
  // with a Q30 Taylor series so no external memory image is needed.
  function automatic logic [DEPTH*RW-1:0] build_rom();
    logic [DEPTH*RW-1:0] img;
    longint theta, x2, term, sum;
    img = '0;
    for (int k = 0; k < DEPTH; k++) begin
      theta = (longint'(1686629713) * longint'(2 * k + 1)) >>> (TABLE_AW + 1);
      x2    = (theta * theta) >>> 30;
      term  = theta;
      sum   = theta;
      for (int i = 1; i < 8; i++) begin
        term = -((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
        sum  = sum + term;
      end
      img[k*RW +: RW] = rom_word_t'((longint'(M) * sum + (longint'(1) <<< 29)) >>> 30);
    end
    return img;
  endfunction

  localparam logic [DEPTH*RW-1:0] ROM_IMG = build_rom();

  logic [PHASE_W-1:0]      acc_q, acc_d, fw_q;
  logic [3:0]              vld_q;
  logic [N-1:0]            p1_q, p1_d, p2_q;
  mode_e                   mode1_q, mode2_q;
  logic [8:0]              scale1_q, scale1_d, scale2_q, scale3_q;
  logic [TABLE_AW-1:0]     addr2_q, addr2_d;
  rom_word_t               rom2_q, mag;
  logic signed [AMP_W-1:0] s3_q, s3_d, mag_s, saw_sat;
  logic signed [N-1:0]     saw_v;
  logic signed [SW-1:0]    saw_ext, saw_sh;
  logic [AMP_W-1:0]        out_q, out_d;

  // Stage 1 inputs: next accumulator, phase index from the pre-add accumulator, clamped gain.
  always_comb begin
    acc_d    = en ? acc_q + fw_q : acc_q;
    p1_d     = N'((acc_q + phase_offset) >> (PHASE_W - N));
    scale1_d = (amp_scale > 9'd256) ? 9'd256 : amp_scale;
    // Odd quadrants walk the table backwards; the half-LSB table offset makes ~a exact.
    addr2_d  = p1_q[N-2] ? ~p1_q[N-3:0] : p1_q[N-3:0];
  end

  // Stage 3 shaping: signed sample in the range +/-M for the mode carried with this sample.
  always_comb begin
    mag     = (mode2_q == MODE_TRI) ? (rom_word_t'(addr2_q) << TRI_SH) : rom2_q;
    mag_s   = signed'({1'b0, mag});
    saw_v   = signed'({~p2_q[N-1], p2_q[N-2:0]});
    saw_ext = SW'(saw_v);
    saw_sh  = (saw_ext <<< SHL) >>> SHR;
    saw_sat = (saw_sh < NEG_MW) ? NEG_M : AMP_W'(saw_sh);
    s3_d    = '0;
    case (mode2_q)
      MODE_SINE, MODE_TRI: s3_d = p2_q[N-1] ? -mag_s : mag_s;
      MODE_SAW:            s3_d = saw_sat;
      default:             s3_d = p2_q[N-1] ? NEG_M : POS_M;
    endcase
  end

  // Stage 4 gain: floor(s*scale/256) stays within +/-M because scale never exceeds 256.
  always_comb begin
    out_d = MID + AMP_W'((PW'(s3_q) * PW'(signed'({1'b0, scale3_q}))) >>> 8);
  end

  // Control state: accumulator, frequency shadow and the valid token pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      fw_q  <= '0;
      vld_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (freq_load) fw_q <= freq_word;
      vld_q <= {vld_q[2:0], en};
    end
  end

  // Datapath stages 1-4; mode and gain ride along with each sample so switches stay clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q     <= '0;
      mode1_q  <= MODE_SINE;
      scale1_q <= '0;
      p2_q     <= '0;
      addr2_q  <= '0;
      rom2_q   <= '0;
      mode2_q  <= MODE_SINE;
      scale2_q <= '0;
      s3_q     <= '0;
      scale3_q <= '0;
      out_q    <= MID;
    end else begin
      p1_q     <= p1_d;
      mode1_q  <= mode_e'(mode);
      scale1_q <= scale1_d;
      p2_q     <= p1_q;
      addr2_q  <= addr2_d;
      rom2_q   <= ROM_IMG[int'(addr2_d)*RW +: RW];
      mode2_q  <= mode1_q;
      scale2_q <= scale1_q;
      s3_q     <= s3_d;
      scale3_q <= scale2_q;
      out_q    <= out_d;
    end
  end

  assign wave_out   = out_q;
  assign wave_valid = vld_q[3];

endmodule

// File: tb/tb_dds_wavegen.sv
// Bench for dds_wavegen at default parameters: reference model feeds a scoreboard queue,
// samples are popped and compared when wave_valid is seen on the falling edge.
module tb_dds_wavegen;

  localparam int PHASE_W = 32;
  localparam int TABLE_AW = 6;
  localparam int AMP_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, freq_load;
  logic [PHASE_W-1:0] freq_word, phase_offset;
  logic [1:0] mode;
  logic [8:0] amp_scale;
  logic [AMP_W-1:0] wave_out;
  logic wave_valid;

  dds_wavegen #(.PHASE_W(PHASE_W), .TABLE_AW(TABLE_AW), .AMP_W(AMP_W)) dut (
    .clk(clk), .rst(rst), .en(en), .freq_word(freq_word), .freq_load(freq_load),
    .phase_offset(phase_offset), .mode(mode), .amp_scale(amp_scale),
    .wave_out(wave_out), .wave_valid(wave_valid)
  );

  typedef struct {int val; int lit; int p; int md; int sc;} exp_t;
  exp_t sb[$];
  int rom_m[64];
  int total = 0;
  int passed = 0;
  logic [31:0] m_acc, m_fw;
  logic [3:0] m_vld;

  function automatic int model(int p, int md, int sc_raw);
    int q, a, addr, mag, s, sc;
    sc = (sc_raw > 256) ? 256 : sc_raw;
    q = p / 64;
    a = p % 64;
    addr = (q % 2 == 1) ? 63 - a : a;
    mag = (md == 0) ? rom_m[addr] : addr * 8;
    case (md)
      0, 1: s = (q >= 2) ? -mag : mag;
      2: begin s = (p - 128) * 4; if (s < -511) s = -511; end
      default: s = (p >= 128) ? -511 : 511;
    endcase
    return ((s * sc) >>> 8) + 512;
  endfunction

  // Hand-derived values for the directed plan points; -1 where none applies.
  function automatic int lit_of(int p, int md, int sc);
    int r;
    r = -1;
    if (md == 0 && sc == 256) begin
      case (p)
        0: r = 518;
        63, 64: r = 1023;
        128: r = 506;
        191: r = 1;
        default: r = -1;
      endcase
    end else if (md == 3 && sc >= 256) r = (p < 128) ? 1023 : 1;
    else if (md == 3 && sc == 128) r = (p < 128) ? 767 : 256;
    else if (md == 1 && sc == 256 && p == 63) r = 1016;
    else if (md == 2 && sc == 256 && p == 0) r = 1;
    else if (md == 2 && sc == 256 && p == 255) r = 1020;
    return r;
  endfunction

  task automatic check(input string tag, input int got, input int want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  task automatic cycle(input logic r, input logic e, input logic fl, input logic [31:0] fw,
                       input logic [31:0] off, input logic [1:0] md, input logic [8:0] sc);
    exp_t x;
    int pm;
    rst = r; en = e; freq_load = fl; freq_word = fw;
    phase_offset = off; mode = md; amp_scale = sc;
    if (r) begin
      sb.delete();
      m_acc = '0;
      m_fw = '0;
      m_vld = '0;
    end else begin
      if (e) begin
        pm = int'((m_acc + off) >> 24);
        x.p = pm; x.md = int'(md); x.sc = int'(sc);
        x.val = model(pm, int'(md), int'(sc));
        x.lit = lit_of(pm, int'(md), int'(sc));
        sb.push_back(x);
        m_acc = m_acc + m_fw;
      end
      if (fl) m_fw = fw;
      m_vld = {m_vld[2:0], e};
    end
    @(posedge clk);
    @(negedge clk);
    if (r) check("reset_out", int'(wave_out), 512);
    check("valid", int'(wave_valid), int'(m_vld[3]));
    if (wave_valid === 1'b1) begin
      check("sb_nonempty", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check($sformatf("sample p=%0d mode=%0d scale=%0d", x.p, x.md, x.sc), int'(wave_out), x.val);
        if (x.lit >= 0)
          check($sformatf("plan p=%0d mode=%0d scale=%0d", x.p, x.md, x.sc), int'(wave_out), x.lit);
      end
    end
  endtask

  task automatic run(input int n, input logic [31:0] off, input logic [1:0] md, input logic [8:0] sc);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0, off, md, sc);
  endtask

  initial begin
    for (int k = 0; k < 64; k++)
      rom_m[k] = int'($floor(511.0 * $sin(3.14159265358979 * 0.5 * (real'(k) + 0.5) / 64.0) + 0.5));

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 9'd256);
    check("reset_valid", int'(wave_valid), 0);

    // 1: fw=0 sine, constant 518 after 4-cycle latency
    cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 2'd0, 9'd256);
    run(10, 32'd0, 2'd0, 9'd256);

    // 2: one phase step per sample, full sine period
    cycle(1'b0, 1'b0, 1'b1, 32'h0100_0000, 32'd0, 2'd0, 9'd256);
    run(260, 32'd0, 2'd0, 9'd256);

    // 3: square at unity, half and over-range gain
    run(256, 32'd0, 2'd3, 9'd256);
    run(256, 32'd0, 2'd3, 9'd128);
    run(256, 32'd0, 2'd3, 9'd300);

    // 4: triangle and sawtooth periods, then per-cycle mode/gain/enable changes
    run(256, 32'd0, 2'd1, 9'd256);
    run(256, 32'd0, 2'd2, 9'd256);
    for (int i = 0; i < 200; i++)
      cycle(1'b0, logic'($urandom_range(0, 3) != 0), 1'b0, 32'd0, 32'd0,
            2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));

    // 5: freq_load together with en near the wrap point, then a quarter-period offset
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 9'd256);
    cycle(1'b0, 1'b0, 1'b1, 32'hFD00_0000, 32'd0, 2'd0, 9'd256);
    cycle(1'b0, 1'b1, 1'b1, 32'h0100_0000, 32'd0, 2'd0, 9'd256);
    run(8, 32'd0, 2'd0, 9'd256);
    run(256, 32'h4000_0000, 2'd0, 9'd256);

    // 6: reset with en high mid-stream, then restart from the offset alone
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 2'd0, 9'd256);
    check("midreset_valid", int'(wave_valid), 0);
    run(6, 32'h1234_5678, 2'd0, 9'd256);

    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 9'd256);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
